// File: rtl/led_frame_buffer_if.sv
// Host write port, driver request/response and swap/status signals of the LED frame buffer.
// clk/reset stay outside as plain ports.
interface led_frame_buffer_if #(
  parameter int IDX_WIDTH   = 1,
  parameter int COLOR_WIDTH = 8
);
  logic                   wr_en_in;
  logic [IDX_WIDTH-1:0]   wr_addr_in;
  logic [COLOR_WIDTH-1:0] wr_green_in;
  logic [COLOR_WIDTH-1:0] wr_red_in;
  logic [COLOR_WIDTH-1:0] wr_blue_in;
  logic                   swap_in;
  logic                   blank_in;
  logic [IDX_WIDTH-1:0]   led_index_in;
  logic                   index_valid_in;
  logic [COLOR_WIDTH-1:0] green_out;
  logic [COLOR_WIDTH-1:0] red_out;
  logic [COLOR_WIDTH-1:0] blue_out;
  logic                   color_valid_out;
  logic                   swap_pending_out;
  logic                   frame_done_out;

  modport master (
    output wr_en_in, wr_addr_in, wr_green_in, wr_red_in, wr_blue_in,
    output swap_in, blank_in, led_index_in, index_valid_in,
    input  green_out, red_out, blue_out, color_valid_out, swap_pending_out, frame_done_out
  );

  modport slave (
    input  wr_en_in, wr_addr_in, wr_green_in, wr_red_in, wr_blue_in,
    input  swap_in, blank_in, led_index_in, index_valid_in,
    output green_out, red_out, blue_out, color_valid_out, swap_pending_out, frame_done_out
  );
endinterface

// File: rtl/led_frame_buffer.sv
// Double-buffered pixel store feeding the LED strand driver: host writes the back bank,
// driver reads the front bank with 2-cycle latency, banks swap only on an index-0 request.
module led_frame_buffer #(
  parameter int NUM_LEDS    = 2,
  parameter int COLOR_WIDTH = 8,
  parameter int IDX_WIDTH   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic clk_in,
  input  logic rst_in,
  led_frame_buffer_if.slave bus
);

  localparam int PW = 3 * COLOR_WIDTH;
  localparam int AW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam logic [IDX_WIDTH:0]   DEPTH    = (IDX_WIDTH+1)'(NUM_LEDS);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_LEDS - 1);

  typedef enum logic {S_IDLE, S_PEND} swap_state_e;

  swap_state_e    state_q, state_d;
  logic           front_sel, swap_apply, rd_bank;
  logic           wr_ok, rd_ok, req_idx0;
  logic [PW-1:0]  bank0 [NUM_LEDS];
  logic [PW-1:0]  bank1 [NUM_LEDS];
  logic [PW-1:0]  wr_px, rd_q, px_q;
  logic           vld_s1, zero_s1, last_s1;
  logic           valid_q, done_q;

  assign wr_px    = {bus.wr_green_in, bus.wr_red_in, bus.wr_blue_in};
  assign wr_ok    = bus.wr_en_in && ({1'b0, bus.wr_addr_in} < DEPTH);
  assign rd_ok    = {1'b0, bus.led_index_in} < DEPTH;
  assign req_idx0 = bus.index_valid_in && (bus.led_index_in == '0);

  always_comb begin
    state_d    = state_q;
    swap_apply = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_idx0 && bus.swap_in) swap_apply = 1'b1;
        else if (bus.swap_in)        state_d    = S_PEND;
      end
      S_PEND: begin
        if (req_idx0) begin
          swap_apply = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The swapping request already reads the bank that is about to become front.
  assign rd_bank = front_sel ^ swap_apply;

  // Bank storage: no reset so it maps onto RAM; writes target the pre-swap back bank.
  always_ff @(posedge clk_in) begin
    if (wr_ok) begin
      if (front_sel) bank0[bus.wr_addr_in[AW-1:0]] <= wr_px;
      else           bank1[bus.wr_addr_in[AW-1:0]] <= wr_px;
    end
    if (bus.index_valid_in)
      rd_q <= rd_bank ? bank1[bus.led_index_in[AW-1:0]] : bank0[bus.led_index_in[AW-1:0]];
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= S_IDLE;
      front_sel <= 1'b0;
      vld_s1    <= 1'b0;
      zero_s1   <= 1'b0;
      last_s1   <= 1'b0;
      px_q      <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (swap_apply) front_sel <= ~front_sel;
      vld_s1 <= bus.index_valid_in;
      if (bus.index_valid_in) begin
        zero_s1 <= bus.blank_in || !rd_ok;
        last_s1 <= (bus.led_index_in == LAST_IDX);
      end
      done_q <= vld_s1 && last_s1;
      // A completing response wins over the invalidation from a newer request.
      if (vld_s1) begin
        valid_q <= 1'b1;
        px_q    <= zero_s1 ? '0 : rd_q;
      end else if (bus.index_valid_in) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign {bus.green_out, bus.red_out, bus.blue_out} = px_q;
  assign bus.color_valid_out  = valid_q;
  assign bus.frame_done_out   = done_q;
  assign bus.swap_pending_out = (state_q == S_PEND);

endmodule

// File: tb/tb_led_frame_buffer.sv
// Bench for led_frame_buffer: directed scenarios plus random traffic, checked against a
// frame-level model (two bank arrays, front/pending flags, queue of due responses).
module tb_led_frame_buffer;
  localparam int N  = 2;
  localparam int CW = 8;
  localparam int IW = 2;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  always #5 clk_in = ~clk_in;

  led_frame_buffer_if #(.IDX_WIDTH(IW), .COLOR_WIDTH(CW)) bus();

  led_frame_buffer #(.NUM_LEDS(N), .COLOR_WIDTH(CW), .IDX_WIDTH(IW)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  typedef struct {
    int          due;
    logic [23:0] px;
    bit          last;
  } resp_t;

  logic [23:0] mem [2][N];
  bit          front, pending;
  logic [23:0] exp_px;
  bit          exp_v, exp_done;
  int          cyc;
  resp_t       rq[$];

  function automatic logic [23:0] dut_px();
    return {bus.green_out, bus.red_out, bus.blue_out};
  endfunction

  task automatic set_idle();
    bus.wr_en_in       = 1'b0;
    bus.wr_addr_in     = '0;
    bus.wr_green_in    = '0;
    bus.wr_red_in      = '0;
    bus.wr_blue_in     = '0;
    bus.swap_in        = 1'b0;
    bus.blank_in       = 1'b0;
    bus.led_index_in   = '0;
    bus.index_valid_in = 1'b0;
  endtask

  task automatic model_reset();
    rq.delete();
    exp_px   = '0;
    exp_v    = 1'b0;
    exp_done = 1'b0;
    front    = 1'b0;
    pending  = 1'b0;
  endtask

  // One clock: advance the model on the inputs currently driven, then compare after the edge.
  task automatic tick();
    bit          req, apply, rb;
    int          idx;
    logic [23:0] px;
    req   = bus.index_valid_in;
    idx   = int'(bus.led_index_in);
    apply = req && (idx == 0) && (pending || bus.swap_in);
    if (req) begin
      rb = front ^ apply;
      if (bus.blank_in || idx >= N) px = '0;
      else                          px = mem[rb][idx];
      rq.push_back('{cyc + 2, px, idx == N - 1});
    end
    if (bus.wr_en_in && int'(bus.wr_addr_in) < N)
      mem[!front][int'(bus.wr_addr_in)] = {bus.wr_green_in, bus.wr_red_in, bus.wr_blue_in};
    if (apply) begin
      front   = !front;
      pending = 1'b0;
    end else if (bus.swap_in) begin
      pending = 1'b1;
    end
    @(posedge clk_in);
    cyc++;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      exp_px   = rq[0].px;
      exp_v    = 1'b1;
      exp_done = rq[0].last;
      void'(rq.pop_front());
    end else begin
      exp_done = 1'b0;
      if (req) exp_v = 1'b0;
    end
    #1;
    chk("valid", 32'(bus.color_valid_out), 32'(exp_v));
    chk("frame_done", 32'(bus.frame_done_out), 32'(exp_done));
    chk("pending", 32'(bus.swap_pending_out), 32'(pending));
    if (!$isunknown(exp_px)) chk("pixel", 32'(dut_px()), 32'(exp_px));
    set_idle();
  endtask

  task automatic wr(int a, logic [23:0] px);
    bus.wr_en_in = 1'b1;
    bus.wr_addr_in = IW'(a);
    {bus.wr_green_in, bus.wr_red_in, bus.wr_blue_in} = px;
    tick();
  endtask

  task automatic rd(int i, bit blank);
    bus.index_valid_in = 1'b1;
    bus.led_index_in   = IW'(i);
    bus.blank_in       = blank;
    tick();
  endtask

  task automatic swap();
    bus.swap_in = 1'b1;
    tick();
  endtask

  initial begin
    set_idle();
    model_reset();
    cyc = 0;

    // Reset state
    rst_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_valid", 32'(bus.color_valid_out), 32'd0);
    chk("rst_done", 32'(bus.frame_done_out), 32'd0);
    chk("rst_pending", 32'(bus.swap_pending_out), 32'd0);
    chk("rst_pixel", 32'(dut_px()), 32'd0);
    rst_in = 1'b1;

    // Fill back bank, swap on the next index-0 request
    wr(0, 24'h102030);
    wr(1, 24'h405060);
    swap();
    chk("s1_pend_set", 32'(bus.swap_pending_out), 32'd1);
    tick();
    rd(0, 1'b0);
    chk("s1_pend_clr", 32'(bus.swap_pending_out), 32'd0);
    tick();
    chk("s1_pixel", 32'(dut_px()), 32'h102030);
    chk("s1_valid", 32'(bus.color_valid_out), 32'd1);

    // Back-to-back requests
    rd(0, 1'b0);
    rd(1, 1'b0);
    chk("pipe_px0", 32'(dut_px()), 32'h102030);
    chk("pipe_done0", 32'(bus.frame_done_out), 32'd0);
    tick();
    chk("pipe_px1", 32'(dut_px()), 32'h405060);
    chk("pipe_done1", 32'(bus.frame_done_out), 32'd1);
    tick();
    chk("pipe_done_end", 32'(bus.frame_done_out), 32'd0);

    // Swap waits for an index-0 request
    wr(1, 24'hFF0000);
    swap();
    rd(1, 1'b0);
    tick();
    chk("gate_old", 32'(dut_px()), 32'h405060);
    chk("gate_pend", 32'(bus.swap_pending_out), 32'd1);
    rd(0, 1'b0);
    rd(1, 1'b0);
    tick();
    chk("gate_new", 32'(dut_px()), 32'hFF0000);

    // Blank and out-of-range
    rd(0, 1'b1);
    tick();
    chk("blank_px", 32'(dut_px()), 32'd0);
    chk("blank_valid", 32'(bus.color_valid_out), 32'd1);
    rd(N, 1'b0);
    tick();
    chk("oor_px", 32'(dut_px()), 32'd0);
    chk("oor_valid", 32'(bus.color_valid_out), 32'd1);
    chk("oor_done", 32'(bus.frame_done_out), 32'd0);
    rd(1, 1'b0);
    tick();
    chk("blank_keeps_ram", 32'(dut_px()), 32'hFF0000);

    // Async reset one cycle after a request
    swap();
    rd(1, 1'b0);
    #2;
    rst_in = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.color_valid_out), 32'd0);
    chk("arst_pixel", 32'(dut_px()), 32'd0);
    chk("arst_pending", 32'(bus.swap_pending_out), 32'd0);
    chk("arst_done", 32'(bus.frame_done_out), 32'd0);
    model_reset();
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    repeat (3) tick();
    chk("arst_no_stale", 32'(bus.color_valid_out), 32'd0);

    // swap_in together with an index-0 request
    wr(0, 24'hABCDEF);
    bus.swap_in        = 1'b1;
    bus.index_valid_in = 1'b1;
    bus.led_index_in   = '0;
    tick();
    chk("simul_pend", 32'(bus.swap_pending_out), 32'd0);
    tick();
    chk("simul_px", 32'(dut_px()), 32'hABCDEF);
    chk("simul_valid", 32'(bus.color_valid_out), 32'd1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      bus.wr_en_in       = ($urandom_range(0, 1) == 1);
      bus.wr_addr_in     = IW'($urandom_range(0, 3));
      bus.wr_green_in    = CW'($urandom);
      bus.wr_red_in      = CW'($urandom);
      bus.wr_blue_in     = CW'($urandom);
      bus.swap_in        = ($urandom_range(0, 9) == 0);
      bus.blank_in       = ($urandom_range(0, 9) == 0);
      bus.index_valid_in = ($urandom_range(0, 9) < 6);
      bus.led_index_in   = ($urandom_range(0, 7) == 0) ? IW'($urandom_range(2, 3))
                                                       : IW'($urandom_range(0, 1));
      tick();
    end
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
